// File: rtl/cu_out_collector.sv
// cu_out_collector: buffers cu output rows in a FIFO and streams them out in lane beats
module cu_out_collector #(
    parameter int ARRAY_HEIGHT  = 16,
    parameter int IN_DATA_WIDTH = 16,
    parameter int OUT_LANES     = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int LOG2_DEPTH    = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ARRAY_HEIGHT*IN_DATA_WIDTH-1:0] i_data_bus,
    input  logic                                  i_data_valid,
    input  logic                                  i_over,
    input  logic                                  i_ready,
    output logic [OUT_LANES*IN_DATA_WIDTH-1:0]    o_data,
    output logic                                  o_valid,
    output logic                                  o_last,
    output logic                                  o_tile_done,
    output logic                                  o_almost_full,
    output logic                                  o_overflow,
    output logic                                  o_err
);
    localparam int BEATS     = ARRAY_HEIGHT / OUT_LANES;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROW_W     = ARRAY_HEIGHT * IN_DATA_WIDTH;
    localparam int BEAT_BITS = OUT_LANES * IN_DATA_WIDTH;
    localparam int CNT_W     = LOG2_DEPTH + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  AF_C      = CNT_W'(FIFO_DEPTH - 2);

    logic [ROW_W-1:0]      r_mem [FIFO_DEPTH];
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_pend_cnt;
    logic [BEAT_W-1:0]     r_beat;
    logic                  r_pending;
    logic                  r_tile_done;
    logic                  r_almost_full;
    logic                  r_overflow;
    logic                  r_err;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [ROW_W-1:0]      w_head;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_last;
    logic                  w_hs;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_clear;

    // Handshake, push/pop decisions and the occupancy the next edge will hold
    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == DEPTH_C);
        w_last      = (r_beat == LAST_BEAT);
        w_hs        = ~w_empty & i_ready;
        w_pop       = w_hs & w_last;
        w_push      = i_data_valid & (~w_full | w_pop);
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_clear     = r_pending & w_pop & (r_pend_cnt == CNT_W'(1));
        w_head      = r_mem[r_rd_ptr];
    end

    assign o_valid       = ~w_empty;
    assign o_last        = ~w_empty & w_last;
    assign o_data        = w_empty ? '0 : w_head[int'(r_beat)*BEAT_BITS +: BEAT_BITS];
    assign o_tile_done   = r_tile_done;
    assign o_almost_full = r_almost_full;
    assign o_overflow    = r_overflow;
    assign o_err         = r_err;

    // Row storage; contents are don't-care until the pointers say otherwise
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data_bus;
    end

    // Pointers, occupancy, beat counter and the backpressure/overflow flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_beat        <= '0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_hs) r_beat <= w_last ? '0 : r_beat + 1'b1;
            if (i_data_valid & ~w_push) r_overflow <= 1'b1;
            r_count       <= w_count_nxt;
            r_almost_full <= (w_count_nxt >= AF_C);
        end
    end

    // Tile-end tracking: count down the rows queued at i_over, pulse done when they are gone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending   <= 1'b0;
            r_pend_cnt  <= '0;
            r_tile_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_tile_done <= 1'b0;
            if (w_clear) begin
                r_pending   <= 1'b0;
                r_tile_done <= 1'b1;
            end else if (r_pending & w_pop) begin
                r_pend_cnt <= r_pend_cnt - 1'b1;
            end
            if (i_over) begin
                if (r_pending & ~w_clear) begin
                    r_err <= 1'b1;
                end else if (w_count_nxt == '0) begin
                    r_tile_done <= 1'b1;
                end else begin
                    r_pending  <= 1'b1;
                    r_pend_cnt <= w_count_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_cu_out_collector.sv
// tb_cu_out_collector: randomized and directed checks of cu_out_collector against a queue model
module tb_cu_out_collector;
    localparam int H = 16, W = 16, L = 4, D = 8;
    localparam int ROW = H * W;
    localparam int BB = L * W;
    localparam int BEATS = H / L;

    logic clk = 1'b0;
    logic rst_n;
    logic [ROW-1:0] i_data_bus;
    logic i_data_valid, i_over, i_ready;
    logic [BB-1:0] o_data;
    logic o_valid, o_last, o_tile_done, o_almost_full, o_overflow, o_err;

    cu_out_collector dut (
        .clk(clk), .rst_n(rst_n), .i_data_bus(i_data_bus), .i_data_valid(i_data_valid),
        .i_over(i_over), .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_last(o_last),
        .o_tile_done(o_tile_done), .o_almost_full(o_almost_full), .o_overflow(o_overflow), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ROW-1:0] mq[$];
    int mid[$];
    int mbeat, mserial, mtarget;
    bit mpend, mtd, maf, movf, merr;

    task automatic chk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int n;
        bit hs, pop, push, clr;
        bit td_n;
        if (!rst_n) begin
            mq.delete(); mid.delete();
            mbeat = 0; mpend = 0; mtd = 0; maf = 0; movf = 0; merr = 0;
            return;
        end
        n = mq.size();
        hs = (n > 0) && i_ready;
        pop = hs && (mbeat == BEATS - 1);
        push = i_data_valid && ((n < D) || pop);
        if (i_data_valid && !push) movf = 1;
        td_n = 0;
        clr = mpend && pop && (mid[0] == mtarget);
        if (clr) begin mpend = 0; td_n = 1; end
        if (pop) begin void'(mq.pop_front()); void'(mid.pop_front()); mbeat = 0; end
        else if (hs) mbeat++;
        if (push) begin mq.push_back(i_data_bus); mid.push_back(mserial); mserial++; end
        if (i_over) begin
            if (mpend) merr = 1;
            else if (mq.size() == 0) td_n = 1;
            else begin mpend = 1; mtarget = mid[$]; end
        end
        maf = (mq.size() >= D - 2);
        mtd = td_n;
    endtask

    task automatic compare();
        logic [ROW-1:0] r;
        logic [BB-1:0] ed;
        bit ev;
        ev = (mq.size() > 0);
        ed = '0;
        if (ev) begin r = mq[0]; ed = r[mbeat*BB +: BB]; end
        chk("o_valid", BB'(o_valid), BB'(ev));
        chk("o_data", o_data, ed);
        chk("o_last", BB'(o_last), BB'(ev && mbeat == BEATS - 1));
        chk("o_tile_done", BB'(o_tile_done), BB'(mtd));
        chk("o_almost_full", BB'(o_almost_full), BB'(maf));
        chk("o_overflow", BB'(o_overflow), BB'(movf));
        chk("o_err", BB'(o_err), BB'(merr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    function automatic logic [ROW-1:0] ramp();
        logic [ROW-1:0] r;
        for (int k = 0; k < H; k++) r[k*W +: W] = W'(k);
        return r;
    endfunction

    function automatic logic [ROW-1:0] rnd_row();
        logic [ROW-1:0] r;
        for (int k = 0; k < ROW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [ROW-1:0] rows3[9];
    logic [ROW-1:0] rr;

    initial begin
        mserial = 0; mtarget = 0;
        rst_n = 1'b0; i_data_bus = '0; i_data_valid = 1'b0; i_over = 1'b0; i_ready = 1'b0;
        tick(); tick();
        chk("reset_valid", BB'(o_valid), BB'(0));
        chk("reset_flags", BB'({o_tile_done, o_almost_full, o_overflow, o_err}), BB'(0));
        rst_n = 1'b1;
        tick();

        // single row, continuous ready
        i_data_bus = ramp(); i_data_valid = 1'b1; i_ready = 1'b1;
        tick();
        i_data_valid = 1'b0;
        chk("t1_beat0", o_data, 64'h0003_0002_0001_0000);
        chk("t1_beat0_last", BB'(o_last), BB'(0));
        tick(); tick(); tick();
        chk("t1_beat3", o_data, 64'h000f_000e_000d_000c);
        chk("t1_beat3_last", BB'(o_last), BB'(1));
        tick();
        chk("t1_empty", BB'(o_valid), BB'(0));

        // ready stall after beat1
        i_data_valid = 1'b1;
        tick();
        i_data_valid = 1'b0;
        tick();
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold", o_data, 64'h0007_0006_0005_0004);
        end
        i_ready = 1'b1;
        tick();
        chk("t2_resume", o_data, 64'h000b_000a_0009_0008);
        tick(); tick();

        // fill past full with ready low
        i_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            rows3[i] = rnd_row();
            i_data_bus = rows3[i]; i_data_valid = 1'b1;
            tick();
            if (i == 4) chk("t3_af_after5", BB'(o_almost_full), BB'(0));
            if (i == 5) chk("t3_af_after6", BB'(o_almost_full), BB'(1));
        end
        i_data_valid = 1'b0;
        chk("t3_overflow", BB'(o_overflow), BB'(1));
        rr = rows3[0];
        chk("t3_head", o_data, rr[BB-1:0]);
        i_ready = 1'b1;
        for (int i = 0; i < 8 * BEATS; i++) tick();
        chk("t3_drained", BB'(o_valid), BB'(0));

        // tile done after three rows drain, then with empty fifo
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_data_bus = rnd_row(); i_data_valid = 1'b1;
            tick();
        end
        i_data_valid = 1'b0; i_over = 1'b1;
        tick();
        i_over = 1'b0; i_ready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        chk("t4_not_yet", BB'(o_tile_done), BB'(0));
        tick();
        chk("t4_done", BB'(o_tile_done), BB'(1));
        tick();
        i_over = 1'b1;
        tick();
        i_over = 1'b0;
        chk("t4_done_empty", BB'(o_tile_done), BB'(1));

        // full fifo with push on the final beat, then second i_over while pending
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        i_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_data_bus = rnd_row(); i_data_valid = 1'b1;
            tick();
        end
        i_data_valid = 1'b0; i_over = 1'b1;
        tick();
        i_over = 1'b0; i_ready = 1'b1;
        tick(); tick(); tick();
        i_data_bus = rnd_row(); i_data_valid = 1'b1;
        tick();
        i_data_valid = 1'b0; i_ready = 1'b0;
        chk("t5_no_overflow", BB'(o_overflow), BB'(0));
        chk("t5_af", BB'(o_almost_full), BB'(1));
        i_over = 1'b1;
        tick();
        i_over = 1'b0;
        chk("t5_err", BB'(o_err), BB'(1));
        i_ready = 1'b1;
        for (int i = 0; i < 8 * BEATS; i++) tick();
        chk("t5_drained", BB'(o_valid), BB'(0));

        // reset mid-row with a tile pending
        i_data_bus = ramp(); i_data_valid = 1'b1; i_over = 1'b1;
        tick();
        i_data_valid = 1'b0; i_over = 1'b0;
        tick(); tick();
        chk("t6_beat2", o_data, 64'h000b_000a_0009_0008);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_valid", BB'(o_valid), BB'(0));
        chk("t6_flags", BB'({o_tile_done, o_almost_full, o_overflow, o_err}), BB'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_no_done", BB'(o_tile_done), BB'(0));
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            i_data_bus = rnd_row();
            i_data_valid = ($urandom_range(0, 99) < 35);
            i_ready = ($urandom_range(0, 99) < 70);
            i_over = ($urandom_range(0, 99) < 4);
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        rst_n = 1'b1; i_data_valid = 1'b0; i_over = 1'b0; i_ready = 1'b1;
        for (int i = 0; i < D * BEATS + 2; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
